// File: rtl/fft_pkg.sv
// Shared constants, sample type and helpers for the FFT output reorder path.
package fft_pkg;

  localparam int unsigned LOG2N = 5;
  localparam int unsigned NPT   = 1 << LOG2N;
  localparam int unsigned DW    = 16;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] addr);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = addr[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame buffer: one synchronous write port, one synchronous read port
// with registered read data (the read register doubles as the output sample).
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [LOG2N-1:0] wr_addr_i,
  input  cplx_t            wr_data_i,
  input  logic             rd_en_i,
  input  logic             rd_bank_i,
  input  logic [LOG2N-1:0] rd_addr_i,
  output cplx_t            rd_data_o
);

  cplx_t mem_q [2*NPT];
  cplx_t rd_data_q;

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
  end

  // Read data holds its value between reads.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_out_reorder.sv
// Buffers bit-reversed FFT output frames in a ping-pong RAM and replays them in
// natural bin order with sof/eof markers. Optional FFT_REORDER_DROP_CNT_EN adds drop_cnt.
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_valid,
  input  logic [DW-1:0]    din_re,
  input  logic [DW-1:0]    din_im,
  output logic             dout_valid,
  output logic [DW-1:0]    dout_re,
  output logic [DW-1:0]    dout_im,
  output logic             dout_sof,
  output logic             dout_eof,
  output logic [LOG2N-1:0] dout_idx
`ifdef FFT_REORDER_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NPT - 1);

  rd_state_t        state_q, state_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_sof_q, dout_sof_d;
  logic             dout_eof_q, dout_eof_d;
  logic [LOG2N-1:0] dout_idx_q, dout_idx_d;
  logic             wr_done;
  logic             rd_en;
  cplx_t            wr_data;
  cplx_t            rd_data;

  assign wr_data = cplx_t'({din_re, din_im});

  fft_pingpong_ram u_ram (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (din_valid),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (bitrev(wr_cnt_q)),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_cnt_q),
    .rd_data_o (rd_data)
  );

  // Write counter, bank select, full flags and read FSM next-state.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    wr_bank_d    = wr_bank_q;
    rd_cnt_d     = rd_cnt_q;
    rd_bank_d    = rd_bank_q;
    full_d       = full_q;
    dout_valid_d = 1'b0;
    dout_sof_d   = 1'b0;
    dout_eof_d   = 1'b0;
    dout_idx_d   = dout_idx_q;
    wr_done      = 1'b0;
    rd_en        = 1'b0;

    if (din_valid) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == LAST_IDX) begin
        wr_done           = 1'b1;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end else if (wr_cnt_q != '0) begin
      wr_cnt_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = READ;
          rd_cnt_d = '0;
        end
      end
      READ: begin
        rd_en        = 1'b1;
        dout_valid_d = 1'b1;
        dout_idx_d   = rd_cnt_q;
        dout_sof_d   = (rd_cnt_q == '0);
        dout_eof_d   = (rd_cnt_q == LAST_IDX);
        rd_cnt_d     = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_IDX) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          rd_cnt_d          = '0;
          // A frame landing in the other bank on this edge still chains seamlessly.
          if (!(full_q[~rd_bank_q] || (wr_done && (wr_bank_q != rd_bank_q)))) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_cnt_q     <= '0;
      rd_bank_q    <= 1'b0;
      full_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
      dout_eof_q   <= 1'b0;
      dout_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      dout_valid_q <= dout_valid_d;
      dout_sof_q   <= dout_sof_d;
      dout_eof_q   <= dout_eof_d;
      dout_idx_q   <= dout_idx_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_sof   = dout_sof_q;
  assign dout_eof   = dout_eof_q;
  assign dout_idx   = dout_idx_q;
  assign dout_re    = rd_data.re;
  assign dout_im    = rd_data.im;

`ifdef FFT_REORDER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of partial frames abandoned on valid loss.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (!din_valid && (wr_cnt_q != '0) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Sink side of the FFT stage-control path.
- The upstream 5-bit control counter steps through sample slots while `valid` is high and returns to 0 when `valid` drops. This block consumes the FFT output stream in that same slot order. Output samples arrive in bit-reversed index order.
- A ping-pong buffer holds each 32-point frame, which is then replayed in natural order (bin 0..31) with frame markers for downstream magnitude/packing logic.

Parameters:
- LOG2N, 5: address bits; must match the upstream control-counter width.
- NPT, 2**LOG2N (=32): points per frame.
- DW, 16: width of each real and imaginary component, two's complement.

Ports:
- clk      input   1    system clock; all logic on rising edge.
- rstn     input   1    reset, synchronous, active-low.
- din_valid  input   1    sample valid; contiguous high for NPT cycles per frame.
- din_re   input   DW   real part, bit-reversed order.
- din_im   input   DW   imaginary part, bit-reversed order.
- dout_valid output  1    natural-order sample valid.
- dout_re  output  DW   real part, natural order.
- dout_im  output  DW   imaginary part, natural order.
- dout_sof output  1    high with bin 0 of each output frame.
- dout_eof output  1    high with bin NPT-1 of each output frame.
- dout_idx output  LOG2N  bin index of the current output sample.

Behaviour:
- **Reset:** clk edge with rstn=0 sets all of the following to 0. Buffer RAM contents are not cleared. Reset mid-frame discards both the partial write and any frame being read.
  - wr_cnt, wr_bank, rd_cnt, rd_bank, full flags
  - state=IDLE
  - outputs: dout_valid, dout_sof, dout_eof, dout_idx, dout_re, dout_im
- **Storage:** 2 banks x NPT entries x 2*DW bits.
- **Write side:**
  - On edge with din_valid=1: write {din_re,din_im} to bank wr_bank at address bitrev(wr_cnt), then wr_cnt++.
  - Edge with din_valid=1 and wr_cnt==NPT-1: frame complete. Set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
  - Edge with din_valid=0 and wr_cnt!=0: partial frame dropped. wr_cnt<=0, wr_bank unchanged, full flag not set. This mirrors the upstream counter clearing on valid loss.
  - Write into a bank whose full flag is still set cannot occur at one sample per cycle. It is not checked, and the data is overwritten.
- **Read FSM states:**
  - IDLE: if full[rd_bank] then go to READ with rd_cnt=0.
  - READ:
    - Each cycle, read bank rd_bank at address rd_cnt into the output register.
    - Output fields: dout_idx=rd_cnt, dout_sof=(rd_cnt==0), dout_eof=(rd_cnt==NPT-1), dout_valid=1.
    - At rd_cnt==NPT-1: clear full[rd_bank] and toggle rd_bank.
    - If full on the other bank is already set, or is being set on this same edge, stay in READ with rd_cnt=0. Output is back-to-back with no gap.
    - Otherwise go to IDLE.
- **Latency:** last input sample accepted at edge T. Bin 0 is visible on dout (registered) after edge T+2, and bin 31 after edge T+33.
- **Throughput:** continuous input yields continuous output, one sample per cycle.
- **Outputs when not valid:** dout_valid=0. dout_re/dout_im hold their last value. sof/eof=0.
- **Simultaneous events:** a write completion and a read completion on the same edge are both applied. The new full flag is visible to the FSM on that same edge.

Optional Feature:
- FFT_REORDER_DROP_CNT_EN defined:
  - Adds output port drop_cnt [7:0].
  - drop_cnt increments on each dropped partial frame and saturates at 255.
  - drop_cnt is cleared only by reset.
- Undefined: port and counter are absent.
- All other behaviour is identical in both builds.

Decomposition:
- Package fft_pkg holds:
  - constants LOG2N=5, NPT, DW
  - typedef cplx_t: struct {re, im} of DW signed each
  - function bitrev(addr), LOG2N bits
  - enum rd_state_t {IDLE, READ}
- One sub-module: fft_pingpong_ram. It has 2 banks, one synchronous write port, one synchronous read port, and registered read data.
- All FSM and counter logic stays in the top.

Test Plan:
- **Single frame:** rstn low 2 cycles, then 32 valid samples with din_re=k, din_im=-k for input slot k. Expect dout_re=bitrev(bin) for bins 0..31, dout_sof at bin 0, dout_eof at bin 31, and bin 0 appearing exactly 2 cycles after the last input.
- **Back-to-back:** 3 frames with continuous din_valid. Expect 96 consecutive dout_valid cycles with sof every 32 and no gaps.
- **Partial drop:** din_valid high 10 cycles, low 1, then a full 32-sample frame. Expect only one output frame, containing the second frame's data. With FFT_REORDER_DROP_CNT_EN, expect drop_cnt=1.
- **Gap between frames:** frame, 5 idle cycles, frame. Expect two output frames separated by exactly 5 invalid cycles. FSM returns to IDLE in between.
- **Reset mid-read:** assert rstn low at output bin 12. Expect dout_valid=0 on the next cycle and no residual output afterwards. A following new frame must output correctly starting from bank 0.
- **Drop saturation (FFT_REORDER_DROP_CNT_EN):** 300 partial frames of 3 samples each. Expect drop_cnt=255 and no output frames.
